rpc_net_mux: RTL

Parametrised network-side serializer/deserializer for the RPC unit. It is the multi-channel successor of the single-path serializer.
- TX: accepts RPC packets from NUM_CH connection-manager channels, buffers each channel in its own FIFO, and round-robin arbitrates onto one NetworkIf with valid/ready backpressure.
- RX: steers each received packet to one channel, selected by connection id.

---
 rtl/rpc_net_mux.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rpc_net_mux.sv
// +--------------------------------------------------------------------------+
// | rpc_net_mux : NUM_CH-channel RPC serializer (per-channel TX FIFOs,       |
// |               round-robin onto one NetworkIf) and RX steering by conn id.|
// | Optional build macro: NIC_RPC_STATS_EN (tx/drop packet counters).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package rpc_net_pkg;
  typedef struct packed {
    logic [7:0] conn_id;
    logic [7:0] rpc_id;
    logic [7:0] opcode;
  } RpcHdr;

  typedef struct packed {
    RpcHdr       hdr;
    logic [31:0] data;
  } RpcPckt;

  typedef struct packed {
    logic [31:0] net_addr;
    RpcPckt      rpc_data;
    logic        valid;
  } CManagerNetRpcIf;

  localparam int PAYLOAD_W = 64;

  typedef struct packed {
    logic [31:0]          addr_tpl;
    logic [PAYLOAD_W-1:0] payload;
    logic                 valid;
  } NetworkIf;
endpackage

module rpc_net_mux
  import rpc_net_pkg::*;
#(
  parameter int NIC_ID     = 0,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  CManagerNetRpcIf ch_net_in [NUM_CH],
  output logic [NUM_CH-1:0] ch_ready_out,
  output CManagerNetRpcIf ch_net_out [NUM_CH],
  output NetworkIf        network_tx_out,
  input  logic            network_tx_ready,
  input  NetworkIf        network_rx_in,
  output logic [31:0]     tx_cnt_out,
  output logic [31:0]     drop_cnt_out,
  output logic            error
);

  localparam int CW    = $clog2(NUM_CH);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RPC_W = $bits(RpcPckt);

  typedef struct packed {
    logic [31:0] net_addr;
    RpcPckt      rpc_data;
  } entry_t;

  entry_t          mem_q    [NUM_CH][FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q [NUM_CH];
  logic [AW:0]     wr_ptr_d [NUM_CH];
  logic [AW:0]     rd_ptr_q [NUM_CH];
  logic [AW:0]     rd_ptr_d [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, pop, drop;

  logic [CW-1:0]   rr_ptr_q, rr_ptr_d, grant, scan_idx;
  logic            any_ne, load;
  entry_t          head;
  NetworkIf        tx_q, tx_d;
  CManagerNetRpcIf rx_q [NUM_CH];
  CManagerNetRpcIf rx_d [NUM_CH];
  RpcPckt          rx_pkt;
  logic            error_q, error_d;

  // A pop frees the slot in the same cycle, so a full FIFO being popped still accepts.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
    assign full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                      (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
    assign push[c]  = ch_net_in[c].valid & (~full[c] | pop[c]);
    assign drop[c]  = ch_net_in[c].valid & full[c] & ~pop[c];
    assign wr_ptr_d[c] = wr_ptr_q[c] + {{AW{1'b0}}, push[c]};
    assign rd_ptr_d[c] = rd_ptr_q[c] + {{AW{1'b0}}, pop[c]};
  end

  assign load = ~tx_q.valid | network_tx_ready;

  always_comb begin
    any_ne   = 1'b0;
    grant    = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = rr_ptr_q + CW'(i);
      if (!any_ne && !empty[scan_idx]) begin
        any_ne = 1'b1;
        grant  = scan_idx;
      end
    end
  end

  assign head = mem_q[grant][rd_ptr_q[grant][AW-1:0]];

  always_comb begin
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    tx_d     = tx_q;
    if (load) begin
      tx_d = '0;
      if (any_ne) begin
        pop[grant]                 = 1'b1;
        rr_ptr_d                   = grant + 1'b1;
        tx_d.addr_tpl              = head.net_addr;
        tx_d.payload[RPC_W-1:0]    = head.rpc_data;
        tx_d.valid                 = 1'b1;
      end
    end
  end

  assign rx_pkt  = network_rx_in.payload[RPC_W-1:0];
  assign error_d = error_q | (|drop);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rx_d[c] = '0;
      if (network_rx_in.valid && (rx_pkt.hdr.conn_id[CW-1:0] == CW'(c))) begin
        rx_d[c].net_addr = network_rx_in.addr_tpl;
        rx_d[c].rpc_data = rx_pkt;
        rx_d[c].valid    = 1'b1;
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c][AW-1:0]] <= {ch_net_in[c].net_addr, ch_net_in[c].rpc_data};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        rx_q[c]     <= '0;
      end
      rr_ptr_q <= '0;
      tx_q     <= '0;
      error_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        rx_q[c]     <= rx_d[c];
      end
      rr_ptr_q <= rr_ptr_d;
      tx_q     <= tx_d;
      error_q  <= error_d;
    end
  end

`ifdef NIC_RPC_STATS_EN
  logic [31:0] tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    tx_cnt_d   = tx_cnt_q + {31'd0, tx_q.valid & network_tx_ready};
    drop_cnt_d = drop_cnt_q + 32'($countones(drop));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_cnt_out   = tx_cnt_q;
  assign drop_cnt_out = drop_cnt_q;
`else
  assign tx_cnt_out   = '0;
  assign drop_cnt_out = '0;
`endif

  assign ch_ready_out   = ~full;
  assign network_tx_out = tx_q;
  assign ch_net_out     = rx_q;
  assign error          = error_q;

  logic unused_ok;
  assign unused_ok = ^{32'(NIC_ID), network_rx_in.payload[PAYLOAD_W-1:RPC_W]};

endmodule

`default_nettype wire
